// File: rtl/stack_sequencer_pkg.sv
// stack_sequencer_pkg: shared types and constants for the stack push/pop sequencer
package stack_sequencer_pkg;
  localparam int NUM_REGS = 16;
  localparam int STACK_WORD_BYTES = 4;
  typedef logic [31:0] t_reg;
  typedef logic [$clog2(NUM_REGS)-1:0] t_reg_index;
  typedef logic [NUM_REGS-1:0] t_reg_mask;
  typedef enum logic [2:0] {IDLE, PUSH_DEC, PUSH_MEM, POP_MEM, FINISH} t_stack_state;
  function automatic t_reg_mask index_bit(t_reg_index i);
    return t_reg_mask'(1) << i;
  endfunction
endpackage

// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if: decode command, register-file and memory-bus signals of the sequencer
interface stack_sequencer_if;
  import stack_sequencer_pkg::*;
  logic start;
  logic push_not_pop;
  t_reg_index sp_index;
  t_reg_mask reg_mask;
  logic busy;
  logic done;
  t_reg_index rf_read_index;
  t_reg rf_read_data;
  t_reg_index rf_sp_index;
  t_reg rf_sp_data;
  logic rf_write;
  t_reg_index rf_write_index;
  t_reg rf_write_data;
  logic rf_inc;
  logic rf_dec;
  t_reg_index rf_incdec_index;
  logic mem_req;
  logic mem_write;
  t_reg mem_address;
  t_reg mem_write_data;
  t_reg mem_read_data;
  logic mem_ack;
  modport master (
    input start, push_not_pop, sp_index, reg_mask, rf_read_data, rf_sp_data, mem_read_data, mem_ack,
    output busy, done, rf_read_index, rf_sp_index, rf_write, rf_write_index, rf_write_data,
    output rf_inc, rf_dec, rf_incdec_index, mem_req, mem_write, mem_address, mem_write_data
  );
  modport slave (
    output start, push_not_pop, sp_index, reg_mask, rf_read_data, rf_sp_data, mem_read_data, mem_ack,
    input busy, done, rf_read_index, rf_sp_index, rf_write, rf_write_index, rf_write_data,
    input rf_inc, rf_dec, rf_incdec_index, mem_req, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/stack_sequencer_mask_priority_encoder.sv
// mask_priority_encoder: picks the highest or lowest set bit of a register mask
module mask_priority_encoder
  import stack_sequencer_pkg::*;
(
  input  t_reg_mask  mask,
  input  logic       highest,
  output t_reg_index index,
  output logic       valid
);
  logic found;
  // ascending scan: the last hit wins for highest, the first hit wins for lowest
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (mask[i] && (highest || !found)) begin
        index = t_reg_index'(i);
        found = 1'b1;
      end
  end
  assign valid = found;
endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-register push/pop controller driving register file and memory bus
module stack_sequencer
  import stack_sequencer_pkg::*;
(
  input logic clock,
  input logic reset,
  stack_sequencer_if.master bus
);
  t_stack_state state, state_next;
  logic dir;
  t_reg_index sp_idx;
  t_reg_mask mask, mask_next, start_mask, clr_mask;
  t_reg_index cur;
  logic cur_valid;
  // push walks from the top register down so a pop (bottom up) restores the same layout
  mask_priority_encoder enc (.mask(mask), .highest(dir), .index(cur), .valid(cur_valid));
  assign start_mask = bus.reg_mask & ~index_bit(bus.sp_index);
  assign clr_mask = mask & ~index_bit(cur);
  // state, working mask and the command latched at start
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mask <= '0;
      dir <= 1'b0;
      sp_idx <= '0;
    end else begin
      state <= state_next;
      mask <= mask_next;
      if (state == IDLE && bus.start) begin
        dir <= bus.push_not_pop;
        sp_idx <= bus.sp_index;
      end
    end
  end
  // next state and all bus/register-file strobes
  always_comb begin
    state_next = state;
    mask_next = mask;
    bus.busy = state != IDLE;
    bus.done = state == FINISH;
    bus.rf_sp_index = sp_idx;
    bus.rf_incdec_index = sp_idx;
    bus.rf_read_index = '0;
    bus.rf_write = 1'b0;
    bus.rf_write_index = '0;
    bus.rf_write_data = '0;
    bus.rf_inc = 1'b0;
    bus.rf_dec = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.mem_write_data = '0;
    case (state)
      IDLE: if (bus.start) begin
        mask_next = start_mask;
        state_next = |start_mask ? (bus.push_not_pop ? PUSH_DEC : POP_MEM) : FINISH;
      end
      PUSH_DEC: begin
        bus.rf_dec = 1'b1;
        state_next = PUSH_MEM;
      end
      PUSH_MEM: begin
        bus.mem_req = cur_valid;
        bus.mem_write = 1'b1;
        bus.mem_address = bus.rf_sp_data;
        bus.mem_write_data = bus.rf_read_data;
        bus.rf_read_index = cur;
        if (bus.mem_ack) begin
          mask_next = clr_mask;
          state_next = |clr_mask ? PUSH_DEC : FINISH;
        end
      end
      POP_MEM: begin
        bus.mem_req = cur_valid;
        bus.mem_address = bus.rf_sp_data;
        if (bus.mem_ack) begin
          bus.rf_write = 1'b1;
          bus.rf_write_index = cur;
          bus.rf_write_data = bus.mem_read_data;
          bus.rf_inc = 1'b1;
          mask_next = clr_mask;
          state_next = |clr_mask ? POP_MEM : FINISH;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Multi-register push/pop controller that drives the register file's write/inc/dec and read ports and the memory bus for one block transfer.
- Sits between instruction decode (start, direction, mask, SP index) and the register file plus data-memory port.
- Push is pre-decrement and pop is post-increment, using the register file's 4-byte inc/dec.
- Memory access is one 32-bit word per register.

Parameters:
NUM_REGS, 16, register count; equals the mask width, and the index width is clog2(NUM_REGS).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin transfer; sampled only in IDLE.
- push_not_pop  in  1  1 = push, 0 = pop; latched at start.
- sp_index  in  t_reg_index  stack pointer register; latched at start.
- reg_mask  in  NUM_REGS  registers to transfer; latched at start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- rf_read_index  out  t_reg_index  register being pushed.
- rf_read_data  in  t_reg  value of rf_read_index.
- rf_sp_index  out  t_reg_index  always the latched SP index.
- rf_sp_data  in  t_reg  current SP value.
- rf_write  out  1  register file write strobe.
- rf_write_index  out  t_reg_index  pop destination.
- rf_write_data  out  t_reg  popped word.
- rf_inc  out  1  SP += 4.
- rf_dec  out  1  SP -= 4.
- rf_incdec_index  out  t_reg_index  equals the latched SP index.
- mem_req  out  1  bus request.
- mem_write  out  1  1 = store.
- mem_address  out  t_reg  byte address (rf_sp_data).
- mem_write_data  out  t_reg  store data.
- mem_read_data  in  t_reg  load data.
- mem_ack  in  1  access completes on this edge.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the working mask clears.
  - All outputs go to 0, including busy and done.
  - SP changes already applied in the register file remain.
- IDLE:
  - With start=1, latch the direction, sp_index and mask.
  - The SP bit is cleared from the working mask; SP is never transferred.
  - Next state: PUSH_DEC or POP_MEM if the working mask is non-zero, otherwise FINISH.
  - start while busy is ignored.
- busy is 1 in every state except IDLE.
- PUSH (highest set index first):
  - PUSH_DEC: rf_dec=1 for exactly one cycle, then go to PUSH_MEM.
  - PUSH_MEM: mem_req=1, mem_write=1, mem_address=rf_sp_data (already decremented), mem_write_data=rf_read_data, with rf_read_index = current register.
  - All request outputs hold stable until the mem_ack edge.
  - On ack, clear that mask bit. Go to PUSH_DEC if bits remain, otherwise FINISH.
- POP (lowest set index first):
  - POP_MEM: mem_req=1, mem_write=0, mem_address=rf_sp_data.
  - In the mem_ack cycle, combinationally assert rf_write=1, rf_write_index = current register, rf_write_data=mem_read_data, and rf_inc=1.
  - The write and the SP increment commit on the same edge.
  - Clear the mask bit. Stay in POP_MEM if bits remain, otherwise FINISH.
- FINISH: done=1 and busy=1 for one cycle, then IDLE. A start in the FINISH cycle is ignored.
- Latency with zero-wait ack (mem_ack high in the request cycle), N = registers transferred:
  - Push: 2N cycles from the first state to FINISH.
  - Pop: N cycles.
  - Empty mask: done occurs in the cycle after start.
- Each wait state adds one cycle. rf_dec is never re-asserted while waiting.
- Exclusivity: rf_inc and rf_dec are never both 1. rf_write and mem_write are never both 1.
- Address arithmetic is 32-bit modulo; wrap-around through 0 is not flagged.
- Priority encode uses highest-set for push and lowest-set for pop, so a round trip restores the original layout.

Decomposition:
- Shared package holds:
  - t_reg (32-bit) and t_reg_index (4-bit).
  - The state enum t_stack_state: IDLE, PUSH_DEC, PUSH_MEM, POP_MEM, FINISH.
  - A constant STACK_WORD_BYTES = 4.
- One sub-module: mask_priority_encoder. It is combinational and takes the mask plus a highest/lowest select. It outputs index and valid.

Test Plan:
- Push, zero-wait:
  - Stimulus: r15=0x1000, r1=0x11111111, r2=0x22222222, mask 0x0006, sp_index 15, zero-wait ack.
  - Required: store 0x22222222 @0x0FFC, then 0x11111111 @0x0FF8, then r15=0x0FF8. done occurs 4 cycles after the first busy cycle.
- Pop round trip:
  - Stimulus: from the state above, clear r1/r2 and pop mask 0x0006.
  - Required: r1=0x11111111 (from 0x0FF8), r2=0x22222222 (from 0x0FFC), r15=0x1000, done after 2 cycles.
- Empty mask and SP-in-mask:
  - Stimulus: mask 0x0000, then mask 0x8001 push with r0=0xDEADBEEF.
  - Required: first case, no mem_req and done the cycle after start. Second case, a single store 0xDEADBEEF @0x0FFC with SP=0x0FFC (r15 not stored).
- Wait states:
  - Stimulus: mem_ack delayed 3 cycles on each push access.
  - Required: mem_address and mem_write_data stable throughout, exactly one rf_dec per register, final SP correct.
- Reset mid-transfer:
  - Stimulus: reset=0 during PUSH_MEM of a 3-register push.
  - Required: busy/done/mem_req/rf_* go to 0 immediately (asynchronously). After release, IDLE accepts a new start normally.
- start while busy:
  - Stimulus: a second start pulse during a pop.
  - Required: ignored; exactly one done pulse.
